// File: rtl/change_capture_queue.sv
// Change capture queue: timestamps each change of a sampled word and
// buffers {value, ts} pairs in a small FIFO with a sticky drop counter.
// Ports: clk, reset (sync, active-high); io_en/io_in sample input;
// io_clear clears overflow/drops; io_out_* valid/ready head entry;
// io_overflow, io_drops, io_count status, all driven from registers.
module change_capture_queue #(
  parameter int DEPTH  = 4,
  parameter int TS_W   = 16,
  parameter int DROP_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       io_en,
  input  logic [31:0]                io_in,
  input  logic                       io_clear,
  input  logic                       io_out_ready,
  output logic                       io_out_valid,
  output logic [31:0]                io_out_bits_data,
  output logic [TS_W-1:0]            io_out_bits_ts,
  output logic                       io_overflow,
  output logic [DROP_W-1:0]          io_drops,
  output logic [$clog2(DEPTH):0]     io_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]     data_mem [DEPTH];
  logic [TS_W-1:0] ts_mem   [DEPTH];

  logic [31:0]     prev_q;
  logic [TS_W-1:0] ts_q;
  logic [AW-1:0]   head_q;
  logic [AW-1:0]   tail_q;
  logic [CW-1:0]   cnt_q;
  logic            valid_q;
  logic            ovf_q;
  logic [DROP_W-1:0] drops_q;

  logic          chg;
  logic          deq;
  logic          enq;
  logic          drop;
  logic          full;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    chg  = io_en && (io_in != prev_q);
    deq  = valid_q && io_out_ready;
    full = (cnt_q == FULL);
    // a full queue still accepts when the head leaves this cycle
    enq  = chg && (!full || deq);
    drop = chg && full && !deq;
    cnt_nxt = cnt_q;
    unique case (1'b1)
      enq && !deq: cnt_nxt = cnt_q + CW'(1);
      !enq && deq: cnt_nxt = cnt_q - CW'(1);
      default:     cnt_nxt = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q  <= '0;
      ts_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      drops_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        ts_mem[i]   <= '0;
      end
    end else begin
      ts_q <= ts_q + TS_W'(1);
      if (io_en) prev_q <= io_in;
      if (enq) begin
        data_mem[tail_q] <= io_in;
        ts_mem[tail_q]   <= ts_q;
        tail_q <= tail_q + AW'(1);
      end
      if (deq) head_q <= head_q + AW'(1);
      cnt_q   <= cnt_nxt;
      valid_q <= (cnt_nxt != '0);
      // clear takes effect first, then a same-cycle drop counts once
      if (io_clear) begin
        ovf_q   <= drop;
        drops_q <= drop ? DROP_W'(1) : '0;
      end else if (drop) begin
        ovf_q   <= 1'b1;
        if (!(&drops_q)) drops_q <= drops_q + DROP_W'(1);
      end
    end
  end

  assign io_out_valid     = valid_q;
  assign io_out_bits_data = data_mem[head_q];
  assign io_out_bits_ts   = ts_mem[head_q];
  assign io_overflow      = ovf_q;
  assign io_drops         = drops_q;
  assign io_count         = cnt_q;

endmodule

// File: tb/tb_change_capture_queue.sv
// Directed bench for change_capture_queue: vector table plus
// hand-written reset and drop-saturation sequences.
module tb_change_capture_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_en = 1'b0;
  logic [31:0] io_in = '0;
  logic        io_clear = 1'b0;
  logic        io_out_ready = 1'b0;
  logic        io_out_valid;
  logic [31:0] io_out_bits_data;
  logic [15:0] io_out_bits_ts;
  logic        io_overflow;
  logic [7:0]  io_drops;
  logic [2:0]  io_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  change_capture_queue #(.DEPTH(4), .TS_W(16), .DROP_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .io_en(io_en),
    .io_in(io_in),
    .io_clear(io_clear),
    .io_out_ready(io_out_ready),
    .io_out_valid(io_out_valid),
    .io_out_bits_data(io_out_bits_data),
    .io_out_bits_ts(io_out_bits_ts),
    .io_overflow(io_overflow),
    .io_drops(io_drops),
    .io_count(io_count)
  );

  typedef struct {
    bit        en;
    bit [31:0] din;
    bit        clr;
    bit        rdy;
    bit        v;
    int        cnt;
    bit [31:0] d;
    int        t;
    bit        o;
    int        dr;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit en, input bit [31:0] din,
                       input bit clr, input bit rdy);
    io_en = en;
    io_in = din;
    io_clear = clr;
    io_out_ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input vec_t e);
    chk({tag, ".valid"}, {31'd0, io_out_valid}, {31'd0, e.v});
    chk({tag, ".count"}, {29'd0, io_count}, e.cnt);
    chk({tag, ".ovf"}, {31'd0, io_overflow}, {31'd0, e.o});
    chk({tag, ".drops"}, {24'd0, io_drops}, e.dr);
    if (e.v) begin
      chk({tag, ".data"}, io_out_bits_data, e.d);
      chk({tag, ".ts"}, {16'd0, io_out_bits_ts}, e.t);
    end
  endtask

  task automatic add(input bit en, input int din, input bit clr,
                     input bit rdy, input bit v, input int cnt,
                     input int d, input int t, input bit o,
                     input int dr);
    vq.push_back('{en, din, clr, rdy, v, cnt, d, t, o, dr});
  endtask

  initial begin
    vec_t e;
    // k = timestamp value at the applying edge
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // k0
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // k1
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // k2
    add(1, 1, 0, 0, 1, 1, 1, 3, 0, 0);   // k3 capture
    add(1, 5, 0, 1, 1, 1, 5, 4, 0, 0);   // k4 enq+deq
    for (int i = 0; i < 10; i++)
      add(1, 5, 0, 0, 1, 1, 5, 4, 0, 0); // k5..k14 hold
    add(0, 9, 0, 0, 1, 1, 5, 4, 0, 0);   // k15 disabled
    add(1, 5, 0, 0, 1, 1, 5, 4, 0, 0);   // k16 prev kept 5
    add(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);   // k17 drain
    add(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);   // k18 ready on empty
    add(1, 0, 0, 0, 1, 1, 0, 19, 0, 0);  // k19
    add(1, 1, 0, 0, 1, 2, 0, 19, 0, 0);  // k20
    add(1, 0, 0, 0, 1, 3, 0, 19, 0, 0);  // k21
    add(1, 1, 0, 0, 1, 4, 0, 19, 0, 0);  // k22 full
    add(1, 0, 0, 0, 1, 4, 0, 19, 1, 1);  // k23 drop
    add(1, 1, 0, 0, 1, 4, 0, 19, 1, 2);  // k24 drop
    add(1, 0, 0, 1, 1, 4, 1, 20, 1, 2);  // k25 full enq+deq
    add(0, 0, 0, 1, 1, 3, 0, 21, 1, 2);  // k26
    add(0, 0, 0, 1, 1, 2, 1, 22, 1, 2);  // k27
    add(0, 0, 0, 1, 1, 1, 0, 25, 1, 2);  // k28 new tail entry
    add(1, 1, 0, 0, 1, 2, 0, 25, 1, 2);  // k29
    add(1, 0, 0, 0, 1, 3, 0, 25, 1, 2);  // k30
    add(1, 1, 0, 0, 1, 4, 0, 25, 1, 2);  // k31
    add(1, 0, 0, 0, 1, 4, 0, 25, 1, 3);  // k32 drop
    add(1, 1, 1, 0, 1, 4, 0, 25, 1, 1);  // k33 clear+drop
    add(0, 1, 1, 0, 1, 4, 0, 25, 0, 0);  // k34 clear
    add(1, 1, 0, 1, 1, 3, 1, 29, 0, 0);  // k35 deq

    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_all("reset", e);
    chk("reset.data", io_out_bits_data, 32'd0);
    chk("reset.ts", {16'd0, io_out_bits_ts}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].en, vq[i].din, vq[i].clr, vq[i].rdy);
      chk_all($sformatf("vec%0d", i), vq[i]);
    end

    // one-cycle reset beats enable, ready and clear
    reset = 1'b1;
    drive(1, 7, 1, 1);
    reset = 1'b0;
    e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_all("midrst", e);
    chk("midrst.ts", {16'd0, io_out_bits_ts}, 32'd0);
    chk("midrst.data", io_out_bits_data, 32'd0);
    drive(0, 7, 0, 0);
    drive(0, 7, 0, 0);
    drive(1, 7, 0, 0);
    e = '{0, 0, 0, 0, 1, 1, 7, 2, 0, 0};
    chk_all("postrst", e);

    // fill then drop 260 times: count saturates at 255
    for (int i = 0; i < 263; i++)
      drive(1, (i % 2 == 0) ? 32'd0 : 32'd7, 0, 0);
    e = '{0, 0, 0, 0, 1, 4, 7, 2, 1, 255};
    chk_all("sat", e);
    drive(1, 7, 0, 0);
    chk("sat.hold", {24'd0, io_drops}, 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
